// File: rtl/bcd_pkg.sv
// Shared types and seven-segment constants for the sequential binary-to-BCD converter.
// Segment codes are active-low, bit order gfedcba.
package bcd_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t SHIFT = 1'b1;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0011000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_OFF;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Combinational BCD digit to active-low seven-segment decode; non-decimal codes blank the digit.
module seg7_encoder
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = digit_to_seg(digit);

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per clock, with overflow flag.
// Optional registered seven-segment output is enabled by defining BCD_SEG7_EN.
//
// state | meaning
// IDLE  | waiting for start; results held
// SHIFT | add-3 correction and shift, one bit per clock
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      num,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
`ifdef BCD_SEG7_EN
    ,
    output logic [7*DIGITS-1:0]   seg
`endif
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t          state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]   work_q, work_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sticky_q, sticky_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            ovf_q, ovf_d;

    logic [BW-1:0]   work_adj;
    logic [BW-1:0]   work_shl;
    logic            top_out;

    // Digits >= 5 get +3 before the shift so they carry correctly into the next digit.
    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
        assign work_adj[4*k +: 4] = (work_q[4*k +: 4] >= 4'd5) ? work_q[4*k +: 4] + 4'd3
                                                               : work_q[4*k +: 4];
    end

    assign work_shl = {work_adj[BW-2:0], shift_q[WIDTH-1]};
    assign top_out  = work_adj[BW-1];

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d  = num;
                    work_d   = '0;
                    sticky_d = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                work_d   = work_shl;
                shift_d  = {shift_q[WIDTH-2:0], 1'b0};
                sticky_d = sticky_q | top_out;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    bcd_d   = work_shl;
                    ovf_d   = sticky_q | top_out;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

`ifdef BCD_SEG7_EN
    logic [7*DIGITS-1:0] seg_q, seg_d;

    // Encode the next bcd value so seg_q updates on the same edge as bcd_q.
    for (genvar k = 0; k < DIGITS; k++) begin : g_seg
        seg7_encoder u_enc (
            .digit (bcd_d[4*k +: 4]),
            .seg   (seg_d[7*k +: 7])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= {DIGITS{SEG_0}};
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg = seg_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a 32-bit/10-digit instance and a 12-bit/3-digit overflow instance.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] num = '0;
    logic        busy, done, ovf;
    logic [39:0] bcd;

    logic        start3 = 1'b0;
    logic [11:0] num3 = '0;
    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;

`ifdef BCD_SEG7_EN
    logic [69:0] seg;
    logic [20:0] seg3;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(32), .DIGITS(10)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .num   (num),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
`ifdef BCD_SEG7_EN
        ,
        .seg   (seg)
`endif
    );

    bin2bcd_seq #(.WIDTH(12), .DIGITS(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start3),
        .num   (num3),
        .busy  (busy3),
        .done  (done3),
        .bcd   (bcd3),
        .ovf   (ovf3)
`ifdef BCD_SEG7_EN
        ,
        .seg   (seg3)
`endif
    );

    typedef struct {
        logic [31:0] num;
        logic [39:0] bcd;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [11:0] num;
        logic [11:0] bcd;
        logic        ovf;
    } vec3_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0: c = 7'b1000000;
            4'd1: c = 7'b1111001;
            4'd2: c = 7'b0100100;
            4'd3: c = 7'b0110000;
            4'd4: c = 7'b0011001;
            4'd5: c = 7'b0010010;
            4'd6: c = 7'b0000010;
            4'd7: c = 7'b1111000;
            4'd8: c = 7'b0000000;
            4'd9: c = 7'b0011000;
            default: c = 7'b1111111;
        endcase
        return c;
    endfunction

    function automatic logic [69:0] seg_of(input logic [39:0] b);
        logic [69:0] s;
        for (int k = 0; k < 10; k++) s[7*k +: 7] = seg_code(b[4*k +: 4]);
        return s;
    endfunction

    task automatic check_seg(input string name, input logic [39:0] eb);
`ifdef BCD_SEG7_EN
        check(name, 128'(seg), 128'(seg_of(eb)));
`endif
    endtask

    // Waits for done; returns the negedge index k (after edge E_k, E0 = accept) and busy-cycle count.
    task automatic wait_done(output int done_k, output int busy_cnt);
        done_k = -1;
        busy_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_k = k;
                break;
            end
        end
    endtask

    task automatic run32(input logic [31:0] n, input logic [39:0] eb, input logic eo);
        int dk, bc;
        @(negedge clk);
        start = 1'b1;
        num = n;
        @(posedge clk);
        #1;
        start = 1'b0;
        num = '0;
        wait_done(dk, bc);
        check("latency", 128'(dk), 128'(32));
        check("busy_cycles", 128'(bc), 128'(32));
        check("bcd", 128'(bcd), 128'(eb));
        check("ovf", 128'(ovf), 128'(eo));
        check_seg("seg", eb);
        @(negedge clk);
        check("done_pulse", 128'(done), 128'(0));
        check("bcd_hold", 128'(bcd), 128'(eb));
    endtask

    task automatic run3(input logic [11:0] n, input logic [11:0] eb, input logic eo);
        int dk;
        @(negedge clk);
        start3 = 1'b1;
        num3 = n;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        num3 = '0;
        dk = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done3) begin
                dk = k;
                break;
            end
        end
        check("latency3", 128'(dk), 128'(12));
        check("bcd3", 128'(bcd3), 128'(eb));
        check("ovf3", 128'(ovf3), 128'(eo));
`ifdef BCD_SEG7_EN
        check("seg3", 128'(seg3), 128'({seg_code(eb[11:8]), seg_code(eb[7:4]), seg_code(eb[3:0])}));
`endif
    endtask

    vec_t  vecs[8];
    vec3_t vecs3[5];

    initial begin
        int dk, bc, pulses;

        vecs[0] = '{32'd0,          40'h0000000000, 1'b0};
        vecs[1] = '{32'd123,        40'h0000000123, 1'b0};
        vecs[2] = '{32'hFFFFFFFF,   40'h4294967295, 1'b0};
        vecs[3] = '{32'd9,          40'h0000000009, 1'b0};
        vecs[4] = '{32'd10,         40'h0000000010, 1'b0};
        vecs[5] = '{32'd65535,      40'h0000065535, 1'b0};
        vecs[6] = '{32'd99999,      40'h0000099999, 1'b0};
        vecs[7] = '{32'd1000000000, 40'h1000000000, 1'b0};

        vecs3[0] = '{12'd1000, 12'h000, 1'b1};
        vecs3[1] = '{12'd999,  12'h999, 1'b0};
        vecs3[2] = '{12'd4095, 12'h095, 1'b1};
        vecs3[3] = '{12'd0,    12'h000, 1'b0};
        vecs3[4] = '{12'd250,  12'h250, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_bcd", 128'(bcd), 128'(0));
        check("rst_ovf", 128'(ovf), 128'(0));
        check_seg("rst_seg", 40'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 128'(busy), 128'(0));

        for (int i = 0; i < 8; i++) run32(vecs[i].num, vecs[i].bcd, vecs[i].ovf);
`ifdef BCD_SEG7_EN
        run32(32'd123, 40'h123, 1'b0);
        check("seg_digit0_123", 128'(seg[6:0]), 128'(7'b0110000));
`endif
        for (int i = 0; i < 5; i++) run3(vecs3[i].num, vecs3[i].bcd, vecs3[i].ovf);

        // start re-pulsed mid-conversion is ignored; start held through done chains a second conversion.
        @(negedge clk);
        start = 1'b1;
        num = 32'd4321;
        @(posedge clk);
        #1;
        start = 1'b0;
        dk = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) begin
                dk = k;
                break;
            end
            if (k == 4) begin
                start = 1'b1;
                num = 32'd77;
            end else if (k == 5) begin
                start = 1'b0;
                num = 32'd4321;
            end else if (k == 31) begin
                start = 1'b1;
                num = 32'd8765;
            end
        end
        check("repulse_latency", 128'(dk), 128'(32));
        check("repulse_bcd", 128'(bcd), 128'(40'h4321));
        @(negedge clk);
        start = 1'b0;
        num = '0;
        check("b2b_busy", 128'(busy), 128'(1));
        check("b2b_done_low", 128'(done), 128'(0));
        wait_done(dk, bc);
        check("b2b_latency", 128'(dk), 128'(31));
        check("b2b_bcd", 128'(bcd), 128'(40'h8765));
        check_seg("b2b_seg", 40'h8765);

        // Reset at cycle 10 of a conversion of 77.
        @(negedge clk);
        start = 1'b1;
        num = 32'd77;
        @(posedge clk);
        #1;
        start = 1'b0;
        num = '0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_done", 128'(done), 128'(0));
        check("midrst_bcd", 128'(bcd), 128'(0));
        check("midrst_ovf", 128'(ovf), 128'(0));
        check_seg("midrst_seg", 40'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("midrst_no_done", 128'(pulses), 128'(0));
        run32(32'd58, 40'h58, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
